// File: rtl/bless_flit_injector.sv
// bless_flit_injector
// Local-port traffic source for a 5-port BLESS bufferless router node.
// Host requests (dest, data) are queued in a 4-entry FIFO. The head entry is launched as a
// single-cycle flit on the router's local input whenever injection is enabled and granted.
// Every flit is stamped with this node's ID and a wrapping sequence number.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge) and asynchronous active-low reset
//   i_enable            injection enable; the FIFO keeps accepting while low
//   i_req_valid/o_req_ready, i_req_dest, i_req_data   host request interface
//   i_inject_ok         router local slot free this cycle
//   o_port_ci/o_port_di registered control/data words to the router local input
//   o_inj_count         flits injected (saturating)
//   o_stall_count       cycles with a pending flit but no grant (saturating)
//   o_fifo_level        FIFO occupancy, 0..4
module bless_flit_injector #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned SEQ_W   = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NODE_ID = 0,
    localparam int unsigned CTRL_W = 1 + 2 * ADDR_W + SEQ_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_dest,
    input  logic [DATA_W-1:0] i_req_data,
    input  logic              i_inject_ok,
    output logic [CTRL_W-1:0] o_port_ci,
    output logic [DATA_W-1:0] o_port_di,
    output logic [15:0]       o_inj_count,
    output logic [15:0]       o_stall_count,
    output logic [2:0]        o_fifo_level
);

    localparam logic [ADDR_W-1:0] SRC_ID = ADDR_W'(NODE_ID);

    // FIFO storage carries no reset: validity is tracked entirely by the pointers and level.
    logic [ADDR_W-1:0] r_dest [4];
    logic [DATA_W-1:0] r_data [4];

    logic [1:0]        r_wptr;
    logic [1:0]        r_rptr;
    logic [2:0]        r_level;
    logic [SEQ_W-1:0]  r_seq;
    logic [CTRL_W-1:0] r_port_ci;
    logic [DATA_W-1:0] r_port_di;
    logic [15:0]       r_inj_count;
    logic [15:0]       r_stall_count;

    logic w_not_empty;
    logic w_push;
    logic w_launch;
    logic w_stall;

    assign w_not_empty = (r_level != 3'd0);
    // Ready comes from registered state only, so a pop at a full edge cannot free a slot
    // for a push at that same edge.
    assign o_req_ready = (r_level != 3'd4);
    assign w_push      = i_req_valid && o_req_ready;
    assign w_launch    = i_enable && i_inject_ok && w_not_empty;
    assign w_stall     = i_enable && w_not_empty && !i_inject_ok;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_dest[r_wptr] <= i_req_dest;
            r_data[r_wptr] <= i_req_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr        <= 2'd0;
            r_rptr        <= 2'd0;
            r_level       <= 3'd0;
            r_seq         <= '0;
            r_port_ci     <= '0;
            r_port_di     <= '0;
            r_inj_count   <= 16'd0;
            r_stall_count <= 16'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end

            unique case ({w_push, w_launch})
                2'b10:   r_level <= r_level + 3'd1;
                2'b01:   r_level <= r_level - 3'd1;
                default: r_level <= r_level;
            endcase

            // Output register is cleared whenever nothing launches, so each flit is
            // presented for exactly one cycle.
            if (w_launch) begin
                r_rptr    <= r_rptr + 2'd1;
                r_port_ci <= {r_seq, SRC_ID, r_dest[r_rptr], 1'b1};
                r_port_di <= r_data[r_rptr];
                r_seq     <= r_seq + SEQ_W'(1);
                if (r_inj_count != 16'hFFFF) begin
                    r_inj_count <= r_inj_count + 16'd1;
                end
            end else begin
                r_port_ci <= '0;
                r_port_di <= '0;
            end

            if (w_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign o_port_ci     = r_port_ci;
    assign o_port_di     = r_port_di;
    assign o_inj_count   = r_inj_count;
    assign o_stall_count = r_stall_count;
    assign o_fifo_level  = r_level;

endmodule

// File: tb/tb_bless_flit_injector.sv
// Directed bench for bless_flit_injector. Accepted requests go into a scoreboard queue;
// each predicted launch pops the head and the next output cycle is compared against it.
module tb_bless_flit_injector;

    localparam int unsigned AW  = 4;
    localparam int unsigned SW  = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned NID = 3;
    localparam int unsigned CW  = 1 + 2 * AW + SW;
    localparam logic [AW-1:0] NID_A = 4'd3;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          valid;
    logic          ready;
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    logic          ok;
    logic [CW-1:0] port_ci;
    logic [DW-1:0] port_di;
    logic [15:0]   inj_count;
    logic [15:0]   stall_count;
    logic [2:0]    level;

    int n_vec;
    int n_err;

    entry_t        sb[$];
    logic [SW-1:0] m_seq;
    logic [15:0]   m_inj;
    logic [15:0]   m_stall;

    bless_flit_injector #(
        .ADDR_W (AW),
        .SEQ_W  (SW),
        .DATA_W (DW),
        .NODE_ID(NID)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (en),
        .i_req_valid  (valid),
        .o_req_ready  (ready),
        .i_req_dest   (dest),
        .i_req_data   (data),
        .i_inject_ok  (ok),
        .o_port_ci    (port_ci),
        .o_port_di    (port_di),
        .o_inj_count  (inj_count),
        .o_stall_count(stall_count),
        .o_fifo_level (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: predict this edge from the model, then compare #1 after it.
    task automatic tick();
        logic          launch;
        logic          stall;
        logic          acc;
        entry_t        head;
        entry_t        e;
        logic [CW-1:0] exp_ci;
        logic [DW-1:0] exp_di;
        check("req_ready", 64'(ready), 64'(sb.size() != 4));
        launch = en && ok && (sb.size() != 0);
        stall  = en && !ok && (sb.size() != 0);
        acc    = valid && (sb.size() != 4);
        head   = '0;
        if (launch) head = sb.pop_front();
        if (acc) begin
            e.dest = dest;
            e.data = data;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        exp_ci = '0;
        exp_di = '0;
        if (launch) begin
            exp_ci = {m_seq, NID_A, head.dest, 1'b1};
            exp_di = head.data;
            m_seq  = m_seq + SW'(1);
            if (m_inj != 16'hFFFF) m_inj = m_inj + 16'd1;
        end
        if (stall && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
        check("port_ci", 64'(port_ci), 64'(exp_ci));
        check("port_di", 64'(port_di), 64'(exp_di));
        check("inj_count", 64'(inj_count), 64'(m_inj));
        check("stall_count", 64'(stall_count), 64'(m_stall));
        check("fifo_level", 64'(level), 64'(sb.size()));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ci", 64'(port_ci), 64'd0);
        check("rst_di", 64'(port_di), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_inj", 64'(inj_count), 64'd0);
        check("rst_stall", 64'(stall_count), 64'd0);
        #1;
        rst_n = 1'b1;
        sb.delete();
        m_seq   = '0;
        m_inj   = 16'd0;
        m_stall = 16'd0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        m_seq   = '0;
        m_inj   = 16'd0;
        m_stall = 16'd0;
        rst_n   = 1'b0;
        en      = 1'b0;
        ok      = 1'b0;
        valid   = 1'b0;
        dest    = '0;
        data    = '0;

        // Reset and idle
        #8;
        check("init_ci", 64'(port_ci), 64'd0);
        check("init_di", 64'(port_di), 64'd0);
        check("init_ready", 64'(ready), 64'd1);
        check("init_level", 64'(level), 64'd0);
        rst_n = 1'b1;
        repeat (10) tick();
        check("idle_inj", 64'(inj_count), 64'd0);
        check("idle_stall", 64'(stall_count), 64'd0);

        // Single flit
        en    = 1'b1;
        ok    = 1'b1;
        valid = 1'b1;
        dest  = 4'd5;
        data  = 32'hDEAD_BEEF;
        tick();
        check("single_early", 64'(port_ci), 64'd0);
        valid = 1'b0;
        tick();
        check("single_ci", 64'(port_ci), 64'({8'h00, 4'h3, 4'h5, 1'b1}));
        check("single_di", 64'(port_di), 64'h0000_0000_DEAD_BEEF);
        tick();
        check("single_clear", 64'(port_ci), 64'd0);
        check("single_inj", 64'(inj_count), 64'd1);

        // Stall then grant
        async_reset();
        ok    = 1'b0;
        valid = 1'b1;
        dest  = 4'd9;
        data  = 32'h1234_5678;
        tick();
        valid = 1'b0;
        repeat (3) tick();
        check("stall_cnt", 64'(stall_count), 64'd3);
        check("stall_hold", 64'(port_ci), 64'd0);
        ok = 1'b1;
        tick();
        check("grant_ci", 64'(port_ci), 64'({8'h00, 4'h3, 4'h9, 1'b1}));
        check("grant_di", 64'(port_di), 64'h0000_0000_1234_5678);
        check("grant_inj", 64'(inj_count), 64'd1);
        check("grant_stall", 64'(stall_count), 64'd3);

        // Full FIFO: 4 of 6 accepted, then in-order back-to-back drain
        async_reset();
        ok    = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dest = AW'(i);
            data = DW'(32'hA000_0000 + i);
            check("full_ready_dir", 64'(ready), 64'(i < 4));
            tick();
        end
        check("full_level", 64'(level), 64'd4);
        valid = 1'b0;
        ok    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("full_seq", 64'(port_ci[CW-1 -: SW]), 64'(i));
            check("full_data", 64'(port_di), 64'(32'hA000_0000 + i));
        end
        tick();
        check("full_done", 64'(port_ci), 64'd0);

        // Pop at a full edge does not admit a push until the next cycle
        async_reset();
        ok    = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = DW'(32'hB000_0000 + i);
            tick();
        end
        ok   = 1'b1;
        data = 32'hB000_00FF;
        tick();
        check("pop_full_level", 64'(level), 64'd3);
        check("pop_full_ready", 64'(ready), 64'd1);
        repeat (3) tick();
        valid = 1'b0;
        repeat (5) tick();

        // Sequence wrap: 257 flits
        async_reset();
        valid = 1'b1;
        for (int i = 0; i < 257; i++) begin
            dest = AW'(i);
            data = DW'(i);
            tick();
        end
        valid = 1'b0;
        tick();
        check("wrap_valid", 64'(port_ci[0]), 64'd1);
        check("wrap_seq", 64'(port_ci[CW-1 -: SW]), 64'd0);
        check("wrap_data", 64'(port_di), 64'd256);
        check("wrap_inj", 64'(inj_count), 64'd257);

        // Mid-operation reset with 3 queued and a flit on the port
        async_reset();
        ok    = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = DW'(32'hC000_0000 + i);
            tick();
        end
        valid = 1'b0;
        ok    = 1'b1;
        tick();
        check("mid_level", 64'(level), 64'd3);
        check("mid_flit", 64'(port_ci[0]), 64'd1);
        async_reset();
        valid = 1'b1;
        dest  = 4'd7;
        data  = 32'h0BAD_F00D;
        tick();
        valid = 1'b0;
        tick();
        check("restart_ci", 64'(port_ci), 64'({8'h00, 4'h3, 4'h7, 1'b1}));
        check("restart_di", 64'(port_di), 64'h0000_0000_0BAD_F00D);

        // Injection counter saturation
        async_reset();
        valid = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            dest = AW'(i);
            data = DW'(i);
            tick();
            if (i == 65534) check("sat_fffe", 64'(inj_count), 64'hFFFE);
        end
        valid = 1'b0;
        repeat (2) tick();
        check("sat_ffff", 64'(inj_count), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
